// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with architectural HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  md_op,
  input  logic        md_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pending_hi;
  logic [31:0]   pending_lo;
  logic          pending_we;

  logic        is_mul;
  logic        is_sdiv;
  logic [63:0] prod;
  logic [31:0] dvd, dvs, q, r;
  logic [31:0] res_hi, res_lo;

  assign start  = (md_op >= OP_MULT) && (md_op <= OP_DIVU) && !busy && !req;
  assign md_out = md_sel ? hi : lo;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly
  always_comb begin
    is_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_sdiv = (md_op == OP_DIV);
    if (md_op == OP_MULT)
      prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    else
      prod = {32'd0, A} * {32'd0, B};
    dvd = (is_sdiv && A[31]) ? (~A + 32'd1) : A;
    dvs = (is_sdiv && B[31]) ? (~B + 32'd1) : B;
    if (B == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = dvd / dvs;
      r = dvd % dvs;
    end
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      res_lo = (is_sdiv && (A[31] ^ B[31])) ? (~q + 32'd1) : q;
      res_hi = (is_sdiv && A[31]) ? (~r + 32'd1) : r;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pending_hi <= res_hi;
            pending_lo <= res_lo;
            // Divide by zero still burns the full latency but leaves HI/LO alone
            pending_we <= is_mul || (B != 32'd0);
            cnt        <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy       <= 1'b1;
            state      <= BUSY;
          end else if (!req && md_op == OP_MTHI) begin
            hi <= A;
          end else if (!req && md_op == OP_MTLO) begin
            lo <= A;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (pending_we) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, located in the EX stage.
- Executes mult/multu/div/divu/mthi/mtlo.
- Its md_out feeds the E-stage result mux ahead of the E→M pipeline register, so mfhi/mflo results travel down the pipe as the ALU result.
- busy is consumed by the hazard unit to stall D-stage md-class instructions.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- req  input  1  exception/interrupt flush from CP0; suppresses any new start or write this cycle.
- md_op  input  4  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, others=none.
- md_sel  input  1  md_out select: 0=LO, 1=HI.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- start  output  1  combinational: md_op in {1..4} && !busy && !req.
- busy  output  1  registered: high while an operation is in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- md_out  output  32  combinational: md_sel ? hi : lo.

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, cnt=0, pending result registers=0.
- Accept:
  - On a rising edge with start==1, latch the result into pending_hi/pending_lo.
  - Load cnt = MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - busy = (cnt!=0), registered.
  - busy is high on the cycle after the accepting edge and stays high for exactly N cycles.
- Count: while cnt>0, decrement by 1 each edge.
- Commit:
  - On the edge where cnt goes 1→0, copy pending_hi/pending_lo into hi/lo; busy falls simultaneously.
  - hi/lo are unchanged until that commit, so mfhi/mflo during busy return old values. The hazard unit stalls them; this unit does not check.
- States:
  - IDLE (cnt==0) → BUSY on start.
  - BUSY → IDLE on the commit edge.
  - There is no other state.
- Arithmetic:
  - mult: {hi,lo} = signed(A) × signed(B), 64-bit.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder, sign of dividend.
  - divu: unsigned quotient in lo, unsigned remainder in hi.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (B==0, div or divu): operation runs the full DIV_CYCLES; hi/lo retain their prior values at commit.
- mthi/mtlo: if !busy && !req, write A to hi/lo on the edge with no latency; busy stays 0.
- md_op nonzero while busy: ignored entirely, no restart and no write. Upstream stalls prevent this in legal flow.
- req:
  - req==1 blocks start and mthi/mtlo in the same cycle; the flushed instruction has no architectural effect.
  - req during BUSY does not cancel the in-flight operation: it belongs to an instruction already past EX, so it runs to commit.
- Reset mid-operation: immediate return to IDLE; the pending result is discarded.
- Simultaneous commit edge and new md_op: busy is still 1 that cycle, so the new op is ignored. It is accepted the following cycle after the hazard-unit stall releases.

Test Plan:
- Reset low, then high; A=7, B=6, md_op=1 for one cycle → busy high for 5 cycles; after commit lo=42, hi=0; md_out follows md_sel.
- div A=0xFFFFFFF9 (-7), B=2 → after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu with the same operands → lo=0x7FFFFFFC, hi=1.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 in back-to-back cycles → hi/lo update on the next edges, busy never asserts. Then div with B=0 → busy for 10 cycles, hi/lo unchanged.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF with req=1 in the same cycle → start=0, busy stays 0, hi/lo unchanged. Repeat with req=0 → hi=0xFFFFFFFE, lo=0x00000001.
- Start mult 3×4, then at busy cycle 2:
  - pulse req=1 → operation still commits lo=12.
  - Separately, pulse reset low at busy cycle 2 → busy=0, hi=lo=0 immediately, and no commit follows.
- During busy, present md_op=6 with A=0xDEAD → lo is not written; the commit value stands. Re-issue after busy falls → lo=0xDEAD on the next edge.
